// File: rtl/bist_signature_analyzer_if.sv
// Response handshake between an AES core (master) and the BIST signature analyser (slave).
interface bist_signature_analyzer_if #(
  parameter int DATA_W = 128
);
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_ready;

  modport master (output resp_valid, output resp_data, input resp_ready);
  modport slave  (input resp_valid, input resp_data, output resp_ready);
endinterface

// File: rtl/bist_signature_analyzer.sv
// MISR-based output-response analyser: folds each response into a signature, counts
// responses in a session and compares the final signature against a latched golden value.
module bist_signature_analyzer #(
  parameter int          DATA_W       = 128,
  parameter int          SIG_W        = 32,
  parameter int          NUM_PATTERNS = 40,
  parameter logic [31:0] SEED         = 32'hFFFFFFFF,
  parameter logic [31:0] TAPS         = 32'h80200003
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [SIG_W-1:0]      golden_sig_i,
  bist_signature_analyzer_if.slave resp_if,
  output logic [SIG_W-1:0]      signature_o,
  output logic [15:0]           pattern_count_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o
);

  localparam int          NUM_SLICES = DATA_W / SIG_W;
  localparam logic [15:0] LAST_CNT   = 16'(NUM_PATTERNS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] golden_q;
  logic [15:0]      cnt_q;
  logic             done_q;
  logic             pass_q;

  logic [SIG_W-1:0] fold;
  logic             fb;
  logic [SIG_W-1:0] sig_d;
  logic             accept;

  // Compact the wide response by XOR-ing its signature-width slices together.
  always_comb begin
    fold = '0;
    for (int i = 0; i < NUM_SLICES; i++) begin
      fold = fold ^ resp_if.resp_data[i*SIG_W +: SIG_W];
    end
  end

  assign fb     = ^(sig_q & TAPS[SIG_W-1:0]);
  assign sig_d  = {sig_q[SIG_W-2:0], fb} ^ fold;
  assign accept = resp_if.resp_valid && (state_q == RUN);

  // Abort takes priority over everything; start is only honoured outside RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sig_q    <= SEED[SIG_W-1:0];
      cnt_q    <= '0;
      golden_q <= '0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else if (abort_i) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_q  <= RUN;
            sig_q    <= SEED[SIG_W-1:0];
            cnt_q    <= '0;
            golden_q <= golden_sig_i;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
          end
        end
        RUN: begin
          if (accept) begin
            sig_q <= sig_d;
            cnt_q <= cnt_q + 16'd1;
            if (cnt_q == LAST_CNT) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              pass_q  <= (sig_d == golden_q);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_if.resp_ready = (state_q == RUN);
  assign busy_o             = (state_q == RUN);
  assign signature_o        = sig_q;
  assign pattern_count_o    = cnt_q;
  assign done_o             = done_q;
  assign pass_o             = pass_q;

endmodule

// File: tb/tb_bist_signature_analyzer.sv
// Directed scoreboard bench for bist_signature_analyzer with a 4-response session.
module tb_bist_signature_analyzer;

  localparam int          NP   = 4;
  localparam logic [31:0] SEED = 32'hFFFFFFFF;
  localparam logic [31:0] TAPS = 32'h80200003;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        startI = 1'b0;
  logic        abortI = 1'b0;
  logic [31:0] goldenI = '0;
  logic [31:0] sigO;
  logic [15:0] cntO;
  logic        busyO, doneO, passO;

  bist_signature_analyzer_if #(.DATA_W(128)) respIf ();

  bist_signature_analyzer #(
    .DATA_W(128), .SIG_W(32), .NUM_PATTERNS(NP), .SEED(SEED), .TAPS(TAPS)
  ) dut (
    .clk(clk), .rst(rst), .start_i(startI), .abort_i(abortI), .golden_sig_i(goldenI),
    .resp_if(respIf), .signature_o(sigO), .pattern_count_o(cntO),
    .busy_o(busyO), .done_o(doneO), .pass_o(passO)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] sbQ[$];
  logic [31:0] mSig;
  int          mCnt;
  logic [127:0] dataSet[NP];
  logic [31:0] golden4;

  // Reference MISR step written straight from the fold/feedback definition.
  function automatic logic [31:0] sigStep(input logic [31:0] s, input logic [127:0] d);
    logic [31:0] f;
    logic        b;
    f = '0;
    for (int i = 0; i < 4; i++) f = f ^ d[i*32 +: 32];
    b = 1'b0;
    for (int k = 0; k < 32; k++) if (TAPS[k]) b = b ^ s[k];
    return {s[30:0], b} ^ f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag, input logic [31:0] expSig, input int expCnt);
    checkOutput({tag, "_ready"}, 32'(respIf.resp_ready), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busyO), 32'd0);
    checkOutput({tag, "_done"}, 32'(doneO), 32'd0);
    checkOutput({tag, "_pass"}, 32'(passO), 32'd0);
    checkOutput({tag, "_sig"}, sigO, expSig);
    checkOutput({tag, "_count"}, 32'(cntO), 32'(expCnt));
  endtask

  task automatic applyStimulusStart(input logic [31:0] golden);
    startI = 1'b1;
    goldenI = golden;
    tick();
    startI = 1'b0;
    mSig = SEED;
    mCnt = 0;
    checkOutput("start_busy", 32'(busyO), 32'd1);
    checkOutput("start_ready", 32'(respIf.resp_ready), 32'd1);
    checkOutput("start_sig", sigO, SEED);
    checkOutput("start_count", 32'(cntO), 32'd0);
  endtask

  // Drive one response, push its predicted signature, pop it after the accepting edge.
  task automatic applyStimulus(input logic [127:0] data, input logic [31:0] expSig, input int gap);
    logic [31:0] popped;
    respIf.resp_data = data;
    respIf.resp_valid = 1'b1;
    sbQ.push_back(expSig);
    mCnt++;
    tick();
    popped = sbQ.pop_front();
    mSig = popped;
    checkOutput("resp_sig", sigO, popped);
    checkOutput("resp_count", 32'(cntO), 32'(mCnt));
    if (gap > 0) begin
      respIf.resp_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        tick();
        checkOutput("gap_sig", sigO, mSig);
        checkOutput("gap_count", 32'(cntO), 32'(mCnt));
      end
    end
  endtask

  task automatic applyModel(input logic [127:0] data, input int gap);
    applyStimulus(data, sigStep(mSig, data), gap);
  endtask

  task automatic checkDone(input string tag, input logic expPass, input logic [31:0] expSig);
    checkOutput({tag, "_done"}, 32'(doneO), 32'd1);
    checkOutput({tag, "_pass"}, 32'(passO), 32'(expPass));
    checkOutput({tag, "_busy"}, 32'(busyO), 32'd0);
    checkOutput({tag, "_ready"}, 32'(respIf.resp_ready), 32'd0);
    checkOutput({tag, "_sig"}, sigO, expSig);
    checkOutput({tag, "_count"}, 32'(cntO), 32'(NP));
  endtask

  task automatic zeroStream();
    applyStimulus('0, 32'hFFFFFFFE, 0);
    applyStimulus('0, 32'hFFFFFFFD, 0);
    applyStimulus('0, 32'hFFFFFFFB, 0);
    applyStimulus('0, 32'hFFFFFFF6, 0);
    respIf.resp_valid = 1'b0;
  endtask

  initial begin
    respIf.resp_valid = 1'b0;
    respIf.resp_data = '0;
    dataSet[0] = 128'h1;
    dataSet[1] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    dataSet[2] = 128'hDEAD_BEEF_0000_FFFF_1234_5678_A5A5_5A5A;
    dataSet[3] = 128'h8000_0000_0000_0001_C0FF_EE00_0BAD_F00D;

    $display("[TB] reset and idle");
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checkIdle("reset", SEED, 0);

    $display("[TB] zero stream, matching golden");
    applyStimulusStart(32'hFFFFFFF6);
    zeroStream();
    checkDone("zeroPass", 1'b1, 32'hFFFFFFF6);
    respIf.resp_valid = 1'b1;
    respIf.resp_data = 128'hFFFF;
    tick();
    respIf.resp_valid = 1'b0;
    checkDone("doneFrozen", 1'b1, 32'hFFFFFFF6);

    $display("[TB] zero stream, wrong golden, restart from DONE");
    applyStimulusStart(32'hFFFFFFF7);
    zeroStream();
    checkDone("zeroFail", 1'b0, 32'hFFFFFFF6);

    $display("[TB] gapped stream with golden change after start");
    golden4 = SEED;
    for (int i = 0; i < NP; i++) golden4 = sigStep(golden4, dataSet[i]);
    applyStimulusStart(golden4);
    goldenI = ~golden4;
    applyStimulus(dataSet[0], 32'hFFFFFFFF, 2);
    for (int i = 1; i < NP; i++) applyModel(dataSet[i], 2);
    checkDone("gapPass", 1'b1, golden4);

    $display("[TB] start ignored mid-run, then abort");
    applyStimulusStart(32'h0);
    applyModel(dataSet[1], 0);
    applyModel(dataSet[2], 0);
    respIf.resp_valid = 1'b0;
    startI = 1'b1;
    tick();
    startI = 1'b0;
    checkOutput("midStart_busy", 32'(busyO), 32'd1);
    checkOutput("midStart_sig", sigO, mSig);
    checkOutput("midStart_count", 32'(cntO), 32'd2);
    abortI = 1'b1;
    respIf.resp_valid = 1'b1;
    tick();
    abortI = 1'b0;
    respIf.resp_valid = 1'b0;
    checkIdle("abort", mSig, 2);
    startI = 1'b1;
    abortI = 1'b1;
    tick();
    startI = 1'b0;
    abortI = 1'b0;
    checkIdle("startAbort", mSig, 2);
    applyStimulusStart(32'h0);

    $display("[TB] reset mid-run");
    applyModel(dataSet[3], 0);
    respIf.resp_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkIdle("asyncRst", SEED, 0);
    tick();
    rst = 1'b0;
    tick();
    checkIdle("postRst", SEED, 0);

    $display("[TB] rerun after reset and from DONE");
    applyStimulusStart(32'hFFFFFFF6);
    zeroStream();
    checkDone("rerun1", 1'b1, 32'hFFFFFFF6);
    applyStimulusStart(32'hFFFFFFF6);
    zeroStream();
    checkDone("rerun2", 1'b1, 32'hFFFFFFF6);
    abortI = 1'b1;
    tick();
    abortI = 1'b0;
    checkIdle("abortDone", 32'hFFFFFFF6, NP);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
